instr_cache: RTL and testbench
==============================

// Module: instr_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the CPU fetch stage and the
//  instruction port of the unified memory. Serves 16-bit fetches on a hit with zero
//  added latency. On a miss, fetches one 4-word (64-bit) line over the fixed-latency
//  memory read port. Keeps saturating hit and miss counters for CPI reporting.
// PARAMETERS
//  WORD_SIZE    16  CPU word width and address width
//  FETCH_SIZE   64  memory line width; always 4 words
//  INDEX_BITS   3   log2 of the line count (8 lines)
//  MEM_LATENCY  6   memory read latency, in cycles, from i_readM rising to valid i_data
// PORTS
//  clk        in   1     single clock, rising edge
//  reset      in   1     asynchronous, active-high
//  cpu_req    in   1     fetch request; held until cpu_ready
//  cpu_addr   in   16    word address of the fetch
//  cpu_ready  out  1     cpu_rdata valid this cycle; request completes
//  cpu_rdata  out  16    fetched instruction word
//  flush      in   1     one-cycle pulse; invalidates every line
//  i_readM    out  1     memory read strobe
//  i_writeM   out  1     tied 0
//  i_address  out  16    line-aligned address {cpu_addr[15:2],2'b00}
//  i_data     in   64    memory line; word k is in bits [16k+15:16k]
//  hit_count  out  16    saturating count of hit completions
//  miss_count out  16    saturating count of misses (fills started)
// BEHAVIOUR
//  Address split: offset=[1:0], index=[INDEX_BITS+1:2], tag=[15:INDEX_BITS+2].
//  Storage per line: valid bit, tag, 64-bit data. All registers; no SRAM macro.
//  Reset values: all valid bits 0, state IDLE, fill counter 0, i_readM 0, i_address 0,
//   cpu_ready 0, hit_count 0, miss_count 0, flush_pend 0.
//  FSM IDLE:
//   - cpu_req asserted and hit: cpu_ready=1 in the same cycle (combinational);
//     cpu_rdata = the word selected by offset; hit_count increments.
//   - cpu_req asserted and miss: next state FILL; cnt<=0; miss_count increments.
//  FSM FILL:
//   - i_readM=1 and i_address stays stable for the whole state.
//   - cnt increments every cycle.
//   - On the edge where cnt==MEM_LATENCY: capture i_data into the indexed line, set
//     its tag and valid bit; next state IDLE.
//   - The re-presented request then hits. A miss costs MEM_LATENCY+2 cycles.
//  cpu_ready=0 throughout FILL; cpu_rdata is don't-care whenever cpu_ready=0.
//  A fill is never aborted; the memory's delay counter does not restart on an aborted
//   strobe. If cpu_req drops or cpu_addr changes mid-FILL, the fill still completes
//   and installs the line for the address latched at miss time.
//  flush in IDLE: all valid bits clear on the next edge. A hit in the same cycle is
//   still served from the pre-flush state.
//  flush in FILL: flush_pend is set. At fill completion, all valid bits clear and the
//   fetched line is NOT installed. flush_pend clears.
//  Counters saturate at 16'hFFFF; no wrap.
//  Asynchronous reset at any point, including mid-FILL, forces the reset values at
//   once. The system resets the memory with it.
// STRUCTURE
//  Shared package: WORD_SIZE, FETCH_SIZE, MEMORY_DELAY constants and the field-slicing
//   functions get_tag, get_index, get_offset. The data cache reuses these.
//  One sub-module: sat_counter16 (inc, out), instantiated for hit_count and miss_count.
//  Tag/valid/data arrays and the IDLE/FILL FSM stay in instr_cache.
// TESTING
//  1 Cold miss: req addr 0x0023 -> i_readM=1 and i_address=0x0020 for 7 cycles; then
//    ready with rdata=mem[0x23]=0x6000; miss_count=1, hit_count=1.
//  2 Spatial hit: after 1, req 0x0021, 0x0022 -> each ready the same cycle with no
//    i_readM; hit_count=3.
//  3 Conflict: req 0x0000, then 0x0020 (same index, other tag), then 0x0000 -> three
//    fills; last rdata=0x9023.
//  4 Flush during FILL: pulse flush at cnt=2 -> fill finishes, line not installed,
//    retried req misses again; miss_count increments.
//  5 Reset mid-FILL: assert reset at cnt=3 -> i_readM=0, counters 0, all lines
//    invalid, same cycle.
//  6 Saturation: force hit_count=0xFFFE, two hits -> stays 0xFFFF.

Source files
------------

// File: rtl/instr_cache_pkg.sv
// Shared cache constants and address field helpers.
// Used by the instruction and data caches.
package instr_cache_pkg;
  localparam int WORD_SIZE    = 16;
  localparam int FETCH_SIZE   = 64;
  localparam int INDEX_BITS   = 3;
  localparam int MEMORY_DELAY = 6;
  localparam int LINES        = 1 << INDEX_BITS;
  localparam int TAG_BITS     = WORD_SIZE - INDEX_BITS - 2;
  localparam int CNT_BITS     = 3;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MEMORY_DELAY);

  typedef enum logic {IDLE, FILL} ic_state_t;

  function automatic logic [TAG_BITS-1:0] get_tag(
    input logic [WORD_SIZE-1:0] a
  );
    return a[WORD_SIZE-1:INDEX_BITS+2];
  endfunction

  function automatic logic [INDEX_BITS-1:0] get_index(
    input logic [WORD_SIZE-1:0] a
  );
    return a[INDEX_BITS+1:2];
  endfunction

  function automatic logic [1:0] get_offset(
    input logic [WORD_SIZE-1:0] a
  );
    return a[1:0];
  endfunction
endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side bundles of the instruction cache.
// master drives the request, slave answers it.
interface icache_cpu_if;
  import instr_cache_pkg::*;
  logic                 cpu_req;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic                 cpu_ready;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 flush;

  modport master (
    output cpu_req, cpu_addr, flush,
    input  cpu_ready, cpu_rdata
  );
  modport slave (
    input  cpu_req, cpu_addr, flush,
    output cpu_ready, cpu_rdata
  );
endinterface

interface icache_mem_if;
  import instr_cache_pkg::*;
  logic                  i_readM;
  logic                  i_writeM;
  logic [WORD_SIZE-1:0]  i_address;
  logic [FETCH_SIZE-1:0] i_data;

  modport master (
    output i_readM, i_writeM, i_address,
    input  i_data
  );
  modport slave (
    input  i_readM, i_writeM, i_address,
    output i_data
  );
endinterface

// File: rtl/instr_cache_sat_counter16.sv
// 16-bit event counter that sticks at all-ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] out
);
  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (inc && r_cnt != 16'hFFFF)
      r_cnt <= r_cnt + 16'd1;
  end

  assign out = r_cnt;
endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache, 8 lines of 4 words.
// Hits answer combinationally; misses fill one line from memory.
module instr_cache
  import instr_cache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  icache_cpu_if.slave  cpu,
  icache_mem_if.master mem,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [FETCH_SIZE-1:0] r_data [LINES];
  ic_state_t             r_state, w_next;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [WORD_SIZE-1:0]  r_addr;
  logic                  r_flush_pend;

  logic [INDEX_BITS-1:0] w_idx, w_fidx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [1:0]            w_off;
  logic                  w_hit, w_miss, w_done, w_drop;

  assign w_idx  = get_index(cpu.cpu_addr);
  assign w_tag  = get_tag(cpu.cpu_addr);
  assign w_off  = get_offset(cpu.cpu_addr);
  assign w_fidx = get_index(r_addr);

  assign w_hit  = (r_state == IDLE) && cpu.cpu_req
                && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss = (r_state == IDLE) && cpu.cpu_req && !w_hit;
  assign w_done = (r_state == FILL) && (r_cnt == LAST_CNT);
  // A flush seen at any point of the fill discards the fetched line.
  assign w_drop = r_flush_pend || cpu.flush;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_miss) w_next = FILL;
      FILL: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_addr <= '0;
    end else if (w_miss) begin
      r_cnt  <= '0;
      r_addr <= {cpu.cpu_addr[WORD_SIZE-1:2], 2'b00};
    end else if (r_state == FILL) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_flush_pend <= 1'b0;
    else if (w_done)
      r_flush_pend <= 1'b0;
    else if (r_state == FILL && cpu.flush)
      r_flush_pend <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_valid <= '0;
    else if (r_state == IDLE && cpu.flush)
      r_valid <= '0;
    else if (w_done && w_drop)
      r_valid <= '0;
    else if (w_done)
      r_valid[w_fidx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_done && !w_drop) begin
      r_tag[w_fidx]  <= get_tag(r_addr);
      r_data[w_fidx] <= mem.i_data;
    end
  end

  assign cpu.cpu_ready = w_hit;
  assign cpu.cpu_rdata = r_data[w_idx][{w_off, 4'b0000} +: WORD_SIZE];

  assign mem.i_readM   = (r_state == FILL);
  assign mem.i_writeM  = 1'b0;
  assign mem.i_address = r_addr;

  sat_counter16 u_hit (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit),
    .out   (hit_count)
  );

  sat_counter16 u_miss (
    .clk   (clk),
    .reset (reset),
    .inc   (w_miss),
    .out   (miss_count)
  );
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache with a fixed-latency memory
// model and an expected-word scoreboard.
module tb_instr_cache;
  logic        clk;
  logic        rst;
  logic [15:0] hc, mc;
  int          passed;
  int          total;
  int          mcnt;
  int          cyc;
  logic [15:0] exp_q [$];

  icache_cpu_if cpu_bus ();
  icache_mem_if mem_bus ();

  instr_cache dut (
    .clk        (clk),
    .reset      (rst),
    .cpu        (cpu_bus),
    .mem        (mem_bus),
    .hit_count  (hc),
    .miss_count (mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0023) return 16'h6000;
    if (a == 16'h0000) return 16'h9023;
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [63:0] mem_line(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    return {mem_word(b | 16'd3), mem_word(b | 16'd2),
            mem_word(b | 16'd1), mem_word(b)};
  endfunction

  // Memory data becomes valid six cycles after the strobe rises.
  always @(posedge clk or posedge rst) begin
    if (rst)
      mcnt <= 0;
    else if (!mem_bus.i_readM)
      mcnt <= 0;
    else if (mcnt < 7)
      mcnt <= mcnt + 1;
  end

  assign mem_bus.i_data = (mcnt >= 6) ? mem_line(mem_bus.i_address)
                                      : 64'hDEAD_BEEF_0BAD_F00D;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Starts at a negedge; returns one negedge after completion.
  task automatic do_fetch(input logic [15:0] a, input int exp_cyc);
    bit          done;
    logic [15:0] e;
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_addr = a;
    exp_q.push_back(mem_word(a));
    cyc  = 0;
    done = 0;
    while (!done && cyc <= 40) begin
      #1;
      if (cpu_bus.cpu_ready) begin
        done = 1;
        e = exp_q.pop_front();
        check("rdata", {48'd0, cpu_bus.cpu_rdata}, {48'd0, e});
        check("readM_at_hit", {63'd0, mem_bus.i_readM}, 64'd0);
      end else begin
        if (cyc > 0)
          check("fill_bus", {47'd0, mem_bus.i_readM, mem_bus.i_address},
                {47'd0, 1'b1, a[15:2], 2'b00});
        @(negedge clk);
        cyc++;
      end
    end
    if (!done)
      check("ready_timeout", {63'd0, cpu_bus.cpu_ready}, 64'd1);
    check("latency", 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
  endtask

  initial begin
    bit          done;
    logic [15:0] e;
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_addr = 16'h0000;
    cpu_bus.flush    = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_readM", {63'd0, mem_bus.i_readM}, 64'd0);
    check("rst_addr", {48'd0, mem_bus.i_address}, 64'd0);
    check("rst_ready", {63'd0, cpu_bus.cpu_ready}, 64'd0);
    check("rst_cnts", {32'd0, hc, mc}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_bus.cpu_req = 1'b0;
    @(negedge clk);

    // cold miss then spatial hits
    do_fetch(16'h0023, 8);
    check("t1_cnts", {32'd0, hc, mc}, {32'd0, 16'd1, 16'd1});
    do_fetch(16'h0021, 0);
    do_fetch(16'h0022, 0);
    check("t2_cnts", {32'd0, hc, mc}, {32'd0, 16'd3, 16'd1});

    // conflict on index 0
    do_fetch(16'h0000, 8);
    do_fetch(16'h0020, 8);
    do_fetch(16'h0000, 8);
    check("t3_cnts", {32'd0, hc, mc}, {32'd0, 16'd6, 16'd4});

    // flush while filling: line dropped, request misses again
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_addr = 16'h0041;
    exp_q.push_back(mem_word(16'h0041));
    repeat (3) @(negedge clk);
    cpu_bus.flush = 1'b1;
    @(negedge clk);
    cpu_bus.flush = 1'b0;
    cyc  = 4;
    done = 0;
    while (!done && cyc <= 40) begin
      #1;
      if (cpu_bus.cpu_ready) begin
        done = 1;
        e = exp_q.pop_front();
        check("t4_rdata", {48'd0, cpu_bus.cpu_rdata}, {48'd0, e});
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done)
      check("t4_timeout", {63'd0, cpu_bus.cpu_ready}, 64'd1);
    check("t4_latency", 64'(cyc), 64'd16);
    @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
    check("t4_cnts", {32'd0, hc, mc}, {32'd0, 16'd7, 16'd6});

    // flush in IDLE with a same-cycle hit
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_addr = 16'h0042;
    cpu_bus.flush    = 1'b1;
    #1;
    check("fl_idle_ready", {63'd0, cpu_bus.cpu_ready}, 64'd1);
    check("fl_idle_rdata", {48'd0, cpu_bus.cpu_rdata},
          {48'd0, mem_word(16'h0042)});
    @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
    cpu_bus.flush   = 1'b0;
    do_fetch(16'h0042, 8);
    check("fl_idle_cnts", {32'd0, hc, mc}, {32'd0, 16'd9, 16'd7});

    // reset mid-fill at cnt==3
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_addr = 16'h0080;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_readM", {63'd0, mem_bus.i_readM}, 64'd0);
    check("t5_addr", {48'd0, mem_bus.i_address}, 64'd0);
    check("t5_cnts", {32'd0, hc, mc}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_bus.cpu_req = 1'b0;
    @(negedge clk);
    do_fetch(16'h0023, 8);
    check("t5_after", {32'd0, hc, mc}, {32'd0, 16'd1, 16'd1});

    // saturation of the hit counter
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_addr = 16'h0023;
    repeat (65533) @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
    check("t6_pre", {48'd0, hc}, 64'h0000_0000_0000_FFFE);
    do_fetch(16'h0022, 0);
    do_fetch(16'h0021, 0);
    check("t6_sat", {32'd0, hc, mc}, {32'd0, 16'hFFFF, 16'd1});

    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
